// File: rtl/scff_lfsr_tester.sv
// On-chip scan-chain tester: fills the chain with a 16-bit LFSR stream, then checks the tail.
// The tail is compared against a reference LFSR loaded with the same seed; all outputs are registered.
module scff_lfsr_tester #(
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = 11
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             hold_i,
    input  logic [15:0]      seed_i,
    output logic             sc_head_o,
    input  logic             sc_tail_i,
    output logic             shift_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [15:0]      err_cnt_o,
    output logic [CNT_W-1:0] first_err_idx_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);

    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    state_t           state_q, state_d;
    logic             shift_en_q, shift_en_d;
    logic             sc_head_q, sc_head_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] first_idx_q, first_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      gen_q, gen_d;
    logic [15:0]      chk_q, chk_d;

    logic [15:0] seed_fix;
    logic        start_ok;
    logic        running;

    always_comb begin
        state_d     = state_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_cnt_d   = err_cnt_q;
        first_idx_d = first_idx_q;
        cnt_d       = cnt_q;
        gen_d       = gen_q;
        chk_d       = chk_q;

        seed_fix = (seed_i == 16'h0000) ? 16'h0001 : seed_i;
        start_ok = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));

        if (abort_i) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            pass_d  = 1'b0;
        end else if (start_ok) begin
            state_d     = S_FILL;
            gen_d       = seed_fix;
            chk_d       = seed_fix;
            cnt_d       = '0;
            err_cnt_d   = '0;
            first_idx_d = '0;
            done_d      = 1'b0;
            pass_d      = 1'b0;
        end else if (shift_en_q) begin
            // shift_en_q is only ever set while in FILL or CHECK
            gen_d = lfsr_step(gen_q);
            cnt_d = cnt_q + CNT_W'(1);
            if (state_q == S_CHECK) begin
                chk_d = lfsr_step(chk_q);
                if (sc_tail_i != chk_q[15]) begin
                    if (err_cnt_q != 16'hFFFF) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                    if (err_cnt_q == 16'h0000) begin
                        first_idx_d = cnt_q;
                    end
                end
            end
            if (cnt_q == LAST_IDX) begin
                cnt_d = '0;
                if (state_q == S_FILL) begin
                    state_d = S_CHECK;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == 16'h0000);
                end
            end
        end

        // The head bit follows the generator, so it naturally holds while shifting is paused.
        running    = (state_d == S_FILL) || (state_d == S_CHECK);
        busy_d     = running;
        shift_en_d = running && !hold_i;
        sc_head_d  = running ? gen_d[15] : 1'b0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            shift_en_q  <= 1'b0;
            sc_head_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            first_idx_q <= '0;
            cnt_q       <= '0;
            gen_q       <= '0;
            chk_q       <= '0;
        end else begin
            state_q     <= state_d;
            shift_en_q  <= shift_en_d;
            sc_head_q   <= sc_head_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            first_idx_q <= first_idx_d;
            cnt_q       <= cnt_d;
            gen_q       <= gen_d;
            chk_q       <= chk_d;
        end
    end

    assign sc_head_o       = sc_head_q;
    assign shift_en_o      = shift_en_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign pass_o          = pass_q;
    assign err_cnt_o       = err_cnt_q;
    assign first_err_idx_o = first_idx_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_scff_lfsr_tester.sv
// Bench for scff_lfsr_tester: a behavioural scan chain with fault injection feeds the DUT,
// and a bit-sequence model predicts the head stream, completion cycle and error report.
module tb_scff_lfsr_tester;
    localparam int L  = 16;
    localparam int CW = 5;

    logic wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    logic          wb_rst_i, start_i, abort_i, hold_i, sc_tail_i;
    logic [15:0]   seed_i;
    logic          sc_head_o, shift_en_o, busy_o, done_o, pass_o;
    logic [15:0]   err_cnt_o;
    logic [CW-1:0] first_err_idx_o;
    logic [1:0]    state_o;

    scff_lfsr_tester #(.CHAIN_LEN(L), .CNT_W(CW)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start_i(start_i), .abort_i(abort_i),
        .hold_i(hold_i), .seed_i(seed_i), .sc_head_o(sc_head_o), .sc_tail_i(sc_tail_i),
        .shift_en_o(shift_en_o), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
        .err_cnt_o(err_cnt_o), .first_err_idx_o(first_err_idx_o), .state_o(state_o)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Chain model: up to 17 flops, tail fault injection during the compare phase.
    logic [16:0] chain;
    int          k;
    logic        chain_clr;
    int          chain_len;
    logic        stuck0;
    logic [15:0] inv_mask;

    always @(posedge wb_clk_i) begin
        if (chain_clr) begin
            chain <= '0;
            k     <= 0;
        end else if (shift_en_o) begin
            chain <= {chain[15:0], sc_head_o};
            k     <= k + 1;
        end
    end

    always_comb begin
        sc_tail_i = chain[5'(chain_len - 1)];
        if ((k >= L) && (k < 2 * L) && inv_mask[4'(k - L)]) sc_tail_i = ~sc_tail_i;
        if (stuck0) sc_tail_i = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    // Expected bit stream b_0..b_31 from the seed rule and the tap equation.
    function automatic logic [31:0] gen_bits(input logic [15:0] seed);
        logic [15:0] s;
        logic [31:0] b;
        s = (seed == 16'h0000) ? 16'h0001 : seed;
        b = '0;
        for (int i = 0; i < 32; i++) begin
            b[i] = s[15];
            s    = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
        end
        return b;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_head"},  32'(sc_head_o),       32'd0);
        chk({tag, "_shen"},  32'(shift_en_o),      32'd0);
        chk({tag, "_busy"},  32'(busy_o),          32'd0);
        chk({tag, "_done"},  32'(done_o),          32'd0);
        chk({tag, "_pass"},  32'(pass_o),          32'd0);
        chk({tag, "_err"},   32'(err_cnt_o),       32'd0);
        chk({tag, "_first"}, 32'(first_err_idx_o), 32'd0);
        chk({tag, "_state"}, 32'(state_o),         32'd0);
    endtask

    task automatic run(input logic [15:0] seed, input int len, input logic stk,
                       input logic [15:0] mask, input int h1_at, input int h1_n,
                       input int h2_at, input int h2_n, input int sp_at, input int abort_k);
        logic [31:0] b;
        logic        t;
        logic        prev_hold;
        int          exp_err, exp_first, exp_done, cyc;
        b         = gen_bits(seed);
        exp_err   = 0;
        exp_first = 0;
        for (int j = 0; j < L; j++) begin
            if (stk) t = 1'b0;
            else if (len == L) t = b[5'(j)] ^ mask[4'(j)];
            else t = ((j == 0) ? 1'b0 : b[5'(j - 1)]) ^ mask[4'(j)];
            if (t != b[5'(j)]) begin
                if (exp_err == 0) exp_first = j;
                exp_err++;
            end
        end
        exp_done = 2 * L + 1 + h1_n + h2_n;

        chain_len = len;
        stuck0    = stk;
        inv_mask  = mask;
        seed_i    = seed;
        start_i   = 1'b1;
        hold_i    = 1'b0;
        chain_clr = 1'b1;
        tick();
        start_i   = 1'b0;
        chain_clr = 1'b0;
        seed_i    = 16'($urandom);
        cyc       = 1;
        chk("c1_state", 32'(state_o),   32'd1);
        chk("c1_busy",  32'(busy_o),    32'd1);
        chk("c1_shen",  32'(shift_en_o), 32'd1);
        chk("c1_done",  32'(done_o),    32'd0);
        chk("c1_err",   32'(err_cnt_o), 32'd0);

        prev_hold = 1'b0;
        while (!done_o && cyc < 200) begin
            if (shift_en_o) chk("head_bit", 32'(sc_head_o), 32'(b[5'(k)]));
            if (prev_hold) chk("hold_shen", 32'(shift_en_o), 32'd0);
            chk("busy_run", 32'(busy_o), 32'd1);
            hold_i  = ((cyc >= h1_at) && (cyc < h1_at + h1_n)) ||
                      ((cyc >= h2_at) && (cyc < h2_at + h2_n));
            start_i = (cyc == sp_at);
            if (abort_k >= 0 && shift_en_o && k == abort_k) begin
                abort_i = 1'b1;
                start_i = 1'b1;
                hold_i  = 1'b0;
                tick();
                abort_i = 1'b0;
                start_i = 1'b0;
                chk("abort_state", 32'(state_o),    32'd0);
                chk("abort_busy",  32'(busy_o),     32'd0);
                chk("abort_done",  32'(done_o),     32'd0);
                chk("abort_head",  32'(sc_head_o),  32'd0);
                chk("abort_shen",  32'(shift_en_o), 32'd0);
                return;
            end
            prev_hold = hold_i;
            tick();
            cyc++;
        end
        hold_i  = 1'b0;
        start_i = 1'b0;
        chk("done_cycle", 32'(cyc),        32'(exp_done));
        chk("done",       32'(done_o),     32'd1);
        chk("done_busy",  32'(busy_o),     32'd0);
        chk("done_state", 32'(state_o),    32'd3);
        chk("done_head",  32'(sc_head_o),  32'd0);
        chk("pass",       32'(pass_o),     32'(exp_err == 0));
        chk("err_cnt",    32'(err_cnt_o),  32'(exp_err));
        if (exp_err != 0) chk("first_idx", 32'(first_err_idx_o), 32'(exp_first));
    endtask

    initial begin
        wb_rst_i  = 1'b1;
        start_i   = 1'b0;
        abort_i   = 1'b0;
        hold_i    = 1'b0;
        seed_i    = 16'h0000;
        chain_clr = 1'b1;
        chain_len = L;
        stuck0    = 1'b0;
        inv_mask  = 16'h0000;
        tick();
        tick();
        chk_all_zero("reset");
        wb_rst_i = 1'b0;
        tick();

        run(16'hACE1, L, 1'b0, 16'h0000, 0, 0, 0, 0, -1, -1);      // ideal chain
        run(16'hACE1, L, 1'b1, 16'h0000, 0, 0, 0, 0, -1, -1);      // tail stuck at 0
        run(16'hACE1, L, 1'b0, 16'h0020, 0, 0, 0, 0, -1, -1);      // bit 5 inverted
        run(16'hACE1, L, 1'b0, 16'h0000, 5, 10, 32, 3, -1, -1);    // holds in FILL and CHECK
        run(16'hACE1, L, 1'b0, 16'h0000, 0, 0, 0, 0, -1, L + 7);   // abort at CHECK index 7
        run(16'h1234, L, 1'b0, 16'h0000, 0, 0, 0, 0, -1, -1);

        seed_i    = 16'hBEEF;
        start_i   = 1'b1;
        chain_clr = 1'b1;
        tick();
        start_i   = 1'b0;
        chain_clr = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        wb_rst_i = 1'b1;
        tick();
        chk_all_zero("midrst");
        wb_rst_i = 1'b0;
        tick();

        run(16'h0000, L, 1'b0, 16'h0000, 0, 0, 0, 0, -1, -1);      // seed 0 behaves as seed 1
        run(16'hACE1, L, 1'b0, 16'h0000, 0, 0, 0, 0, 8, -1);       // start pulse mid-FILL
        run(16'hACE1, L + 1, 1'b0, 16'h0000, 0, 0, 0, 0, -1, -1);  // one extra flop

        for (int r = 0; r < 8; r++) begin
            run(16'($urandom), L, 1'b0, 16'($urandom & $urandom & $urandom),
                int'($urandom_range(2, 10)), int'($urandom_range(0, 5)), 0, 0,
                int'($urandom_range(2, 30)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
